router_fsm_ctrl: RTL and testbench

Control state machine for the 1x3 packet router. It sits beside `router_sync` and the input register block. It decodes the header address and sequences the first-data, payload, full-stall and parity phases. It drives the load/strobe controls and `busy` back-pressure, and abandons a packet when the synchronizer soft-resets its destination FIFO.

---
 rtl/router_pkg.sv | 30 +++
 rtl/router_port_sel.sv | 42 ++++
 rtl/router_fsm_ctrl.sv | 177 +++++++++++++++++
 tb/tb_router_fsm_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router control path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    // Header address that never maps to a destination FIFO.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Control FSM states; DROP is only reachable when invalid-address dropping is built in.
    typedef enum logic [3:0] {
        ST_DA   = 4'd0,   // decode header address
        ST_LFD  = 4'd1,   // load first data (header byte)
        ST_LD   = 4'd2,   // load payload
        ST_FFS  = 4'd3,   // destination FIFO full, stalled
        ST_LAF  = 4'd4,   // load the byte held during the stall
        ST_LP   = 4'd5,   // load parity byte
        ST_CPE  = 4'd6,   // check parity error
        ST_WTE  = 4'd7,   // wait for destination FIFO to drain
        ST_DROP = 4'd8    // discard packet with invalid address
    } router_fsm_state_t;

    // True when a header address selects one of the existing destination FIFOs.
    function automatic logic addr_in_range(input int addr, input int num_ports);
        return (addr < num_ports);
    endfunction

endpackage

// File: rtl/router_port_sel.sv
// Selects the empty flag and soft reset of the destination FIFO named by addr.
// Latency: purely combinational.
// Backpressure: none; addresses with no FIFO read as not-empty and no soft reset.
module router_port_sel #(
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    output logic              sel_empty,
    output logic              sel_soft_reset
);

    // Per-address mux; unmapped addresses never look empty so they can never start a load.
    always_comb begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        case (int'(addr))
            0: begin
                sel_empty      = fifo_empty_0;
                sel_soft_reset = soft_reset_0;
            end
            1: begin
                sel_empty      = fifo_empty_1;
                sel_soft_reset = soft_reset_1;
            end
            2: begin
                sel_empty      = fifo_empty_2;
                sel_soft_reset = soft_reset_2;
            end
            default: begin
                sel_empty      = 1'b0;
                sel_soft_reset = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router control FSM: decodes header address, sequences first-data/payload/full-stall/parity phases.
// Latency: header accepted on edge N -> first data strobe N+1, first FIFO write N+2; Moore outputs.
// Backpressure: busy holds the source; ROUTER_FSM_DROP_INVALID_EN adds a DROP state for invalid addresses.
module router_fsm_ctrl #(
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              write_enb_reg,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy,
    output logic [ADDR_W-1:0] dest_sel
);

    import router_pkg::*;

    router_fsm_state_t state_q, state_d;
    logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;

    logic addr_ok;
    logic live_empty;
    logic unused_live_soft_reset;
    logic dest_empty;
    logic dest_soft_reset;

    assign addr_ok = addr_in_range(int'(data_in), NUM_PORTS);

    // Live header address: decides LFD vs WTE while decoding.
    router_port_sel #(.ADDR_W(ADDR_W)) u_sel_live (
        .addr           (data_in),
        .fifo_empty_0   (fifo_empty_0),
        .fifo_empty_1   (fifo_empty_1),
        .fifo_empty_2   (fifo_empty_2),
        .soft_reset_0   (soft_reset_0),
        .soft_reset_1   (soft_reset_1),
        .soft_reset_2   (soft_reset_2),
        .sel_empty      (live_empty),
        .sel_soft_reset (unused_live_soft_reset)
    );

    // Latched destination: drain wait and packet abandon on read timeout.
    router_port_sel #(.ADDR_W(ADDR_W)) u_sel_dest (
        .addr           (dest_sel_q),
        .fifo_empty_0   (fifo_empty_0),
        .fifo_empty_1   (fifo_empty_1),
        .fifo_empty_2   (fifo_empty_2),
        .soft_reset_0   (soft_reset_0),
        .soft_reset_1   (soft_reset_1),
        .soft_reset_2   (soft_reset_2),
        .sel_empty      (dest_empty),
        .sel_soft_reset (dest_soft_reset)
    );

    // Next state: destination soft reset abandons any in-flight packet, else phase transitions.
    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        if ((state_q != ST_DA) && dest_soft_reset) begin
            state_d = ST_DA;
        end else begin
            case (state_q)
                ST_DA: begin
                    if (pkt_valid && addr_ok) begin
                        state_d = live_empty ? ST_LFD : ST_WTE;
                    end
`ifdef ROUTER_FSM_DROP_INVALID_EN
                    else if (pkt_valid) begin
                        state_d = ST_DROP;
                    end
`endif
                end
                ST_LFD:  state_d = ST_LD;
                ST_LD: begin
                    if (fifo_full)       state_d = ST_FFS;
                    else if (!pkt_valid) state_d = ST_LP;
                end
                ST_FFS: begin
                    if (!fifo_full) state_d = ST_LAF;
                end
                ST_LAF: begin
                    if (parity_done)        state_d = ST_DA;
                    else if (low_pkt_valid) state_d = ST_LP;
                    else                    state_d = ST_LD;
                end
                ST_LP:   state_d = ST_CPE;
                ST_CPE:  state_d = fifo_full ? ST_FFS : ST_DA;
                ST_WTE: begin
                    if (dest_empty) state_d = ST_LFD;
                end
`ifdef ROUTER_FSM_DROP_INVALID_EN
                ST_DROP: begin
                    if (!pkt_valid) state_d = ST_DA;
                end
`endif
                default: state_d = ST_DA;
            endcase
        end
        // The header address is captured whenever decoding hands off to another state.
        if ((state_q == ST_DA) && (state_d != ST_DA)) begin
            dest_sel_d = data_in;
        end
    end

    // State and destination registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DA;
            dest_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state_q)
            ST_DA:   detect_add = 1'b1;
            ST_LFD: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            ST_LD: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_FFS: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            ST_LAF: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            ST_LP: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            ST_CPE: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            ST_WTE:  busy        = 1'b1;
            ST_DROP: rst_int_reg = 1'b1;
            default: detect_add  = 1'b0;
        endcase
    end

    assign dest_sel = dest_sel_q;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl against a phase-level reference model.
// Latency: model advances once per rising edge; outputs sampled 1 time unit later.
// Backpressure: random fifo_full/empty/soft_reset stimulus exercises busy and stalls.
module tb_router_fsm_ctrl;

    import router_pkg::*;

    logic              clk;
    logic              reset;
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic              soft_reset_0, soft_reset_1, soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              detect_add, write_enb_reg, lfd_state, ld_state;
    logic              laf_state, full_state, rst_int_reg, busy;
    logic [ADDR_W-1:0] dest_sel;

    int checks = 0;
    int errors = 0;

    router_fsm_ctrl #(.ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .dest_sel      (dest_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: packet phase plus latched destination.
    localparam int P_DA = 0, P_LFD = 1, P_LD = 2, P_FFS = 3, P_LAF = 4;
    localparam int P_LP = 5, P_CPE = 6, P_WTE = 7, P_DROP = 8;
    // Expected strobes per phase: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}.
    localparam logic [7:0] OUT_TBL [9] = '{8'h80, 8'h41, 8'h24, 8'h09, 8'h15,
                                           8'h05, 8'h03, 8'h01, 8'h02};
    int                m_ph   = P_DA;
    logic [ADDR_W-1:0] m_dest = '0;

    function automatic logic empty_of(input logic [ADDR_W-1:0] a);
        case (int'(a))
            0: return fifo_empty_0;
            1: return fifo_empty_1;
            2: return fifo_empty_2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic soft_of(input logic [ADDR_W-1:0] a);
        case (int'(a))
            0: return soft_reset_0;
            1: return soft_reset_1;
            2: return soft_reset_2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        int nx;
        nx = m_ph;
        if (reset) begin
            m_ph   = P_DA;
            m_dest = '0;
        end else begin
            if (m_ph != P_DA && soft_of(m_dest)) nx = P_DA;
            else begin
                case (m_ph)
                    P_DA: begin
                        if (pkt_valid && int'(data_in) < NUM_PORTS)
                            nx = empty_of(data_in) ? P_LFD : P_WTE;
`ifdef ROUTER_FSM_DROP_INVALID_EN
                        else if (pkt_valid) nx = P_DROP;
`endif
                    end
                    P_LFD:  nx = P_LD;
                    P_LD:   nx = fifo_full ? P_FFS : (!pkt_valid ? P_LP : P_LD);
                    P_FFS:  nx = fifo_full ? P_FFS : P_LAF;
                    P_LAF:  nx = parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
                    P_LP:   nx = P_CPE;
                    P_CPE:  nx = fifo_full ? P_FFS : P_DA;
                    P_WTE:  nx = empty_of(m_dest) ? P_LFD : P_WTE;
                    P_DROP: nx = pkt_valid ? P_DROP : P_DA;
                    default: nx = P_DA;
                endcase
            end
            if (m_ph == P_DA && nx != P_DA) m_dest = data_in;
            m_ph = nx;
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    function automatic logic [7+ADDR_W:0] dut_vec();
        return {dut_outs(), dest_sel};
    endfunction

    function automatic logic [7+ADDR_W:0] model_vec();
        return {OUT_TBL[m_ph], m_dest};
    endfunction

    // One rising edge: advance the model with the inputs the DUT saw, then settle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        reset = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        cycle();
        cycle();
        checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL reset_detect_add got=%b exp=1", detect_add); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (write_enb_reg !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", write_enb_reg); end
        checks++; if (dest_sel !== '0) begin errors++; $display("FAIL reset_dest got=%0d exp=0", dest_sel); end
        checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL reset_vec got=%b exp=%b", dut_vec(), model_vec()); end
        reset = 1'b0;
    endtask

    task automatic test_packet();
        int wr_cnt = 0;
        drive_idle();
        data_in = 2'd1; pkt_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) pkt_valid = 1'b0;
            cycle();
            if (write_enb_reg === 1'b1) wr_cnt++;
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL packet_step%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
            if (i == 0) begin
                checks++; if (lfd_state !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL packet_lfd got lfd=%b busy=%b exp 1 1", lfd_state, busy); end
            end
        end
        checks++; if (wr_cnt != 5) begin errors++; $display("FAIL packet_write_cycles got=%0d exp=5", wr_cnt); end
        checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL packet_back_to_da got=%b exp=1", detect_add); end
    endtask

    task automatic test_wait_empty();
        int wte_cnt = 0;
        drive_idle();
        data_in = 2'd2; fifo_empty_2 = 1'b0; pkt_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) fifo_empty_2 = 1'b1;
            cycle();
            if (dut_outs() === 8'h01) wte_cnt++;
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL wte_step%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
        end
        checks++; if (wte_cnt != 6) begin errors++; $display("FAIL wte_cycles got=%0d exp=6", wte_cnt); end
        checks++; if (lfd_state !== 1'b1 || dest_sel !== 2'd2) begin errors++; $display("FAIL wte_exit got lfd=%b dest=%0d exp 1 2", lfd_state, dest_sel); end
        pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL wte_tail%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
        end
    endtask

    task automatic test_full_stall();
        // Per step: {pkt_valid, fifo_full, parity_done, low_pkt_valid}
        logic [3:0] stim [14] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1010,
                                  4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        int full_cnt = 0;
        drive_idle();
        data_in = 2'd0;
        for (int i = 0; i < 14; i++) begin
            {pkt_valid, fifo_full, parity_done, low_pkt_valid} = stim[i];
            cycle();
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL full_step%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
            if (i >= 2 && i <= 4 && full_state === 1'b1 && write_enb_reg === 1'b0) full_cnt++;
            if (i == 5) begin
                checks++; if (laf_state !== 1'b1) begin errors++; $display("FAIL full_laf got=%b exp=1", laf_state); end
            end
            if (i == 6) begin
                checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL full_parity_done_da got=%b exp=1", detect_add); end
            end
            if (i == 11) begin
                checks++; if (dut_outs() !== 8'h05) begin errors++; $display("FAIL full_low_pkt_lp got=%b exp=00000101", dut_outs()); end
            end
        end
        checks++; if (full_cnt != 3) begin errors++; $display("FAIL full_stall_cycles got=%0d exp=3", full_cnt); end
    endtask

    task automatic test_soft_reset();
        drive_idle();
        data_in = 2'd0; pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            soft_reset_1 = (i == 3);
            soft_reset_0 = (i == 4);
            cycle();
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL soft_step%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
            if (i == 3) begin
                checks++; if (ld_state !== 1'b1) begin errors++; $display("FAIL soft_other_port got ld=%b exp=1", ld_state); end
            end
        end
        checks++; if (detect_add !== 1'b1 || write_enb_reg !== 1'b0) begin errors++; $display("FAIL soft_abandon got da=%b wr=%b exp 1 0", detect_add, write_enb_reg); end
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        data_in = 2'd2; pkt_valid = 1'b1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; pkt_valid = 1'b0;
        checks++; if (detect_add !== 1'b1 || dest_sel !== '0) begin errors++; $display("FAIL reset_mid got da=%b dest=%0d exp 1 0", detect_add, dest_sel); end
    endtask

    task automatic test_invalid_addr();
        int hit = 0;
        int wr_cnt = 0;
        drive_idle();
        data_in = ADDR_INVALID; pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) pkt_valid = 1'b0;
            cycle();
            if (write_enb_reg === 1'b1) wr_cnt++;
`ifdef ROUTER_FSM_DROP_INVALID_EN
            if (i < 4 && dut_outs() === 8'h02) hit++;
`else
            if (i < 4 && dut_outs() === 8'h80) hit++;
`endif
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL invalid_step%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
        end
        checks++; if (hit != 4) begin errors++; $display("FAIL invalid_hold_cycles got=%0d exp=4", hit); end
        checks++; if (wr_cnt != 0) begin errors++; $display("FAIL invalid_writes got=%0d exp=0", wr_cnt); end
        checks++; if (detect_add !== 1'b1) begin errors++; $display("FAIL invalid_end_da got=%b exp=1", detect_add); end
    endtask

    task automatic test_random();
        drive_idle();
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(199) == 0);
            pkt_valid     = ($urandom_range(99) < 85);
            data_in       = ADDR_W'($urandom_range(3));
            fifo_full     = ($urandom_range(99) < 20);
            fifo_empty_0  = ($urandom_range(99) < 60);
            fifo_empty_1  = ($urandom_range(99) < 60);
            fifo_empty_2  = ($urandom_range(99) < 60);
            soft_reset_0  = ($urandom_range(99) < 3);
            soft_reset_1  = ($urandom_range(99) < 3);
            soft_reset_2  = ($urandom_range(99) < 3);
            parity_done   = ($urandom_range(99) < 15);
            low_pkt_valid = ($urandom_range(99) < 15);
            cycle();
            checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL random_cycle%0d got=%b exp=%b", i, dut_vec(), model_vec()); end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_packet();
        test_wait_empty();
        test_full_stall();
        test_soft_reset();
        test_reset_mid();
        test_invalid_addr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
